// File: rtl/module7_pkg.sv
// Shared types and helpers for the module7 input arbiter.
// The round-robin search is written once here so every arbiter resolves ties the same way.
package module7_pkg;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_NR_REQUESTERS = 4;
    localparam int MAX_REQUESTERS    = 16;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    // First set bit of valid at or above ptr, wrapping at nr-1 back to 0.
    function automatic logic [3:0] rr_next_idx(
        input logic [MAX_REQUESTERS-1:0] valid,
        input logic [3:0]                ptr,
        input int                        nr
    );
        logic       found;
        logic [3:0] idx;
        int         j;
        found = 1'b0;
        idx   = ptr;
        for (int i = 0; i < MAX_REQUESTERS; i++) begin
            if (i < nr) begin
                j = int'(ptr) + i;
                if (j >= nr) j = j - nr;
                if (!found && valid[j[3:0]]) begin
                    found = 1'b1;
                    idx   = j[3:0];
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/module7_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot winner among valid requesters, starting at ptr_i.
// Reusable by any arbiter that keeps its own pointer.
module rr_picker
    import module7_pkg::*;
#(
    parameter int NR = DEF_NR_REQUESTERS
) (
    input  logic [NR-1:0]         valid_i,
    input  logic [$clog2(NR)-1:0] ptr_i,
    output logic [NR-1:0]         grant_o,
    output logic                  any_o
);

    logic [MAX_REQUESTERS-1:0] valid_ext;
    logic [3:0]                idx;

    always_comb begin
        valid_ext           = '0;
        valid_ext[NR-1:0]   = valid_i;
        idx                 = rr_next_idx(valid_ext, 4'(ptr_i), NR);
        any_o               = |valid_i;
        grant_o             = '0;
        for (int k = 0; k < NR; k++) begin
            grant_o[k] = any_o && (idx == 4'(k));
        end
    end

endmodule

// File: rtl/module7_arbiter.sv
// Round-robin packet arbiter in front of module7.data_i: one requester owns the output for a
// whole packet (or MAX_BEATS beats, whichever ends first) through a single registered stage.
module module7_arbiter
    import module7_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int NR_REQUESTERS = DEF_NR_REQUESTERS,
    parameter int MAX_BEATS     = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NR_REQUESTERS-1:0]       req_valid_i,
    input  logic [NR_REQUESTERS*WIDTH-1:0] req_data_i,
    input  logic [NR_REQUESTERS-1:0]       req_last_i,
    output logic [NR_REQUESTERS-1:0]       req_ready_o,
    output logic [WIDTH-1:0]               data_o,
    output logic                           valid_o,
    output logic                           last_o,
    input  logic                           ready_i,
    output logic [NR_REQUESTERS-1:0]       grant_o,
    output logic                           trunc_o
);

    localparam int PTR_W = $clog2(NR_REQUESTERS);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    state_e                   state_q,    state_d;
    ptr_t                     rr_ptr_q,   rr_ptr_d;
    cnt_t                     beat_cnt_q, beat_cnt_d;
    logic [NR_REQUESTERS-1:0] grant_q,    grant_d;
    logic [WIDTH-1:0]         data_q,     data_d;
    logic                     valid_q,    valid_d;
    logic                     last_q,     last_d;
    logic                     trunc_q,    trunc_d;

    logic [NR_REQUESTERS-1:0] pick_grant;
    logic                     pick_any;
    logic [NR_REQUESTERS-1:0] req_ready;
    ptr_t                     g_idx;
    ptr_t                     next_ptr;
    logic                     accept;
    logic [WIDTH-1:0]         sel_data;
    logic                     sel_last;
    logic                     at_max;
    logic                     pkt_last;

    rr_picker #(
        .NR (NR_REQUESTERS)
    ) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NR_REQUESTERS; k++) begin
            if (grant_q[k]) g_idx = ptr_t'(k);
        end
        // The granted source may only push when the output slot is empty or draining this cycle.
        req_ready = (state_q == BURST) ? (grant_q & {NR_REQUESTERS{~valid_q | ready_i}}) : '0;
        accept    = |(req_valid_i & req_ready);
        sel_data  = req_data_i[g_idx*WIDTH +: WIDTH];
        sel_last  = req_last_i[g_idx];
        at_max    = (beat_cnt_q == cnt_t'(MAX_BEATS - 1));
        pkt_last  = sel_last | at_max;
        next_ptr  = (g_idx == ptr_t'(NR_REQUESTERS - 1)) ? '0 : g_idx + 1'b1;
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no path leaves it unassigned,
        // which is what keeps this block from inferring latches.
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        trunc_d    = 1'b0;

        if (accept) begin
            data_d  = sel_data;
            valid_d = 1'b1;
            last_d  = pkt_last;
            trunc_d = at_max & ~sel_last;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    if (pkt_last) begin
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            trunc_q    <= trunc_d;
        end
    end

    assign req_ready_o = req_ready;
    assign grant_o     = grant_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign last_o      = last_q;
    assign trunc_o     = trunc_q;

endmodule

// File: tb/tb_module7_arbiter.sv
// Directed bench for module7_arbiter: per-requester beat sources, an output transfer log and a
// grant-order log, compared against hand-written expected sequences.
module tb_module7_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_last_i;
    logic [3:0]   req_ready_o;
    logic [31:0]  data_o;
    logic         valid_o;
    logic         last_o;
    logic         ready_i;
    logic [3:0]   grant_o;
    logic         trunc_o;

    module7_arbiter #(
        .WIDTH         (32),
        .NR_REQUESTERS (4),
        .MAX_BEATS     (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .ready_i     (ready_i),
        .grant_o     (grant_o),
        .trunc_o     (trunc_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] src_data [4][24];
    bit          src_last [4][24];
    int          src_len  [4];
    int          src_pos  [4];

    logic [31:0] out_data [128];
    bit          out_last [128];
    int          out_n;
    int          grant_log [16];
    int          gn;
    logic [3:0]  prev_grant;
    int          multi_grant;
    int          trunc_cnt;
    logic [31:0] trunc_data;
    bit          trunc_last;

    logic [31:0] exp_data [128];
    bit          exp_last [128];
    int          exp_n;
    bit          tb_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        out_n       = 0;
        gn          = 0;
        prev_grant  = '0;
        multi_grant = 0;
        trunc_cnt   = 0;
        trunc_data  = '0;
        trunc_last  = 1'b0;
        exp_n       = 0;
    endtask

    task automatic clear_src();
        for (int k = 0; k < 4; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
    endtask

    task automatic add_beat(input int k, input logic [31:0] d, input bit l);
        src_data[k][src_len[k]] = d;
        src_last[k][src_len[k]] = l;
        src_len[k]++;
    endtask

    task automatic exp_push(input logic [31:0] d, input bit l);
        exp_data[exp_n] = d;
        exp_last[exp_n] = l;
        exp_n++;
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, the DUT acts at the next rising edge.
    task automatic cycle();
        @(negedge clk_i);
        ready_i = tb_ready;
        for (int k = 0; k < 4; k++) begin
            if (src_pos[k] < src_len[k]) begin
                req_valid_i[k]          = 1'b1;
                req_data_i[k*32 +: 32]  = src_data[k][src_pos[k]];
                req_last_i[k]           = src_last[k][src_pos[k]];
            end else begin
                req_valid_i[k]          = 1'b0;
                req_data_i[k*32 +: 32]  = '0;
                req_last_i[k]           = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            if (req_valid_i[k] && req_ready_o[k]) src_pos[k]++;
        end
        if (valid_o && ready_i) begin
            out_data[out_n] = data_o;
            out_last[out_n] = last_o;
            out_n++;
        end
        if (grant_o != 4'b0 && prev_grant == 4'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (grant_o[k]) grant_log[gn] = k;
            end
            gn++;
        end
        prev_grant = grant_o;
        if ($countones(grant_o) > 1) multi_grant++;
        if (trunc_o) begin
            trunc_cnt++;
            trunc_data = data_o;
            trunc_last = last_o;
        end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        bit done;
        bit empty;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            cycle();
            empty = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (src_pos[k] < src_len[k]) empty = 1'b0;
            end
            done = empty && !valid_o && (grant_o == 4'b0);
        end
        check(tag, done, 1);
    endtask

    task automatic check_log(input string tag);
        check($sformatf("%s_count", tag), out_n, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            if (i < out_n) begin
                check($sformatf("%s_data%0d", tag, i), out_data[i], exp_data[i]);
                check($sformatf("%s_last%0d", tag, i), out_last[i], exp_last[i]);
            end
        end
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tb_ready    = 1'b1;
        ready_i     = 1'b1;
        clear_src();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        clear_logs();
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        ready_i     = 1'b1;
        tb_ready    = 1'b1;
        clear_src();
        clear_logs();

        // Reset values
        @(negedge clk_i);
        check("rst_grant", grant_o, 4'b0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 32'h0);
        check("rst_last", last_o, 0);
        check("rst_trunc", trunc_o, 0);
        check("rst_ready", req_ready_o, 4'b0);
        do_reset();

        // Reset mid-burst: requester 1, 5-beat packet, reset after 3 accepts
        for (int i = 0; i < 5; i++) add_beat(1, 32'h10 + i, i == 4);
        for (int i = 0; i < 20 && src_pos[1] < 3; i++) cycle();
        check("mid_pre_accepts", src_pos[1], 3);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_grant", grant_o, 4'b0);
        check("mid_valid", valid_o, 0);
        check("mid_data", data_o, 32'h0);
        check("mid_last", last_o, 0);
        check("mid_trunc", trunc_o, 0);
        check("mid_ready", req_ready_o, 4'b0);
        src_pos[1] = 0;
        clear_logs();
        @(negedge clk_i);
        rst_i = 1'b0;
        drain("mid_drain", 40);
        check("mid_gn", gn, 1);
        check("mid_g0", grant_log[0], 1);
        for (int i = 0; i < 5; i++) exp_push(32'h10 + i, i == 4);
        check_log("mid_log");

        // Single requester 2, 4-beat packet, cycle-exact
        clear_src();
        clear_logs();
        for (int i = 0; i < 4; i++) add_beat(2, 32'hA0 + i, i == 3);
        cycle();
        check("s2_idle_grant", grant_o, 4'b0);
        cycle();
        check("s2_grant", grant_o, 4'b0100);
        check("s2_req_ready", req_ready_o, 4'b0100);
        cycle();
        check("s2_d0", data_o, 32'hA0);
        check("s2_v0", valid_o, 1);
        check("s2_l0", last_o, 0);
        cycle();
        check("s2_d1", data_o, 32'hA1);
        check("s2_l1", last_o, 0);
        cycle();
        check("s2_d2", data_o, 32'hA2);
        check("s2_l2", last_o, 0);
        cycle();
        check("s2_d3", data_o, 32'hA3);
        check("s2_l3", last_o, 1);
        check("s2_released", grant_o, 4'b0);
        cycle();
        check("s2_v_clear", valid_o, 0);
        check("s2_d_hold", data_o, 32'hA3);

        // All four valid with 2-beat packets
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) begin
                add_beat(k, 32'h1000 + 16 * k + j, j == 1);
                exp_push(32'h1000 + 16 * k + j, j == 1);
            end
        end
        drain("all_drain", 80);
        check("all_onehot", multi_grant, 0);
        check("all_gn", gn, 4);
        for (int k = 0; k < 4; k++) check($sformatf("all_g%0d", k), grant_log[k], k);
        check_log("all_log");

        // Backpressure on requester 3's second beat
        clear_src();
        clear_logs();
        for (int i = 0; i < 4; i++) add_beat(3, 32'h30 + i, i == 3);
        for (int i = 0; i < 20 && !(valid_o && data_o == 32'h30); i++) cycle();
        check("bp_first", data_o, 32'h30);
        tb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("bp_data%0d", i), data_o, 32'h31);
            check($sformatf("bp_valid%0d", i), valid_o, 1);
            check($sformatf("bp_last%0d", i), last_o, 0);
            check($sformatf("bp_rdy%0d", i), req_ready_o[3], 0);
        end
        tb_ready = 1'b1;
        drain("bp_drain", 40);
        for (int i = 0; i < 4; i++) exp_push(32'h30 + i, i == 3);
        check_log("bp_log");

        // Truncation at 16 beats; requester 1 goes next, requester 0's tail in the following round
        clear_src();
        clear_logs();
        for (int i = 0; i < 20; i++) add_beat(0, 32'h400 + i, i == 19);
        add_beat(1, 32'h500, 1'b0);
        add_beat(1, 32'h501, 1'b1);
        drain("tr_drain", 200);
        check("tr_count", trunc_cnt, 1);
        check("tr_data", trunc_data, 32'h40F);
        check("tr_last", trunc_last, 1);
        check("tr_gn", gn, 3);
        check("tr_g0", grant_log[0], 0);
        check("tr_g1", grant_log[1], 1);
        check("tr_g2", grant_log[2], 0);
        for (int i = 0; i < 16; i++) exp_push(32'h400 + i, i == 15);
        exp_push(32'h500, 1'b0);
        exp_push(32'h501, 1'b1);
        for (int i = 16; i < 20; i++) exp_push(32'h400 + i, i == 19);
        check_log("tr_log");

        // Requester at rr_ptr-1 alone, single-beat packets: one IDLE cycle between grants
        clear_src();
        clear_logs();
        add_beat(0, 32'h600, 1'b1);
        add_beat(0, 32'h601, 1'b1);
        cycle();
        check("rg_idle0", grant_o, 4'b0);
        cycle();
        check("rg_grant0", grant_o, 4'b0001);
        cycle();
        check("rg_idle1", grant_o, 4'b0);
        check("rg_out0", data_o, 32'h600);
        check("rg_out0_last", last_o, 1);
        cycle();
        check("rg_grant1", grant_o, 4'b0001);
        drain("rg_drain", 20);
        exp_push(32'h600, 1'b1);
        exp_push(32'h601, 1'b1);
        check_log("rg_log");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
